// File: rtl/apb_slave_pkg.sv
// Shared types, widths and address-decode helper for the APB slave memory model.
package apb_slave_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;
    localparam logic [APB_ADDR_W-1:0] DEFAULT_ADDR_BASE = 32'h8000_0000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Subtraction-based compare so base + span never has to be formed (no wrap at 2^32).
    function automatic logic addr_in_range(input logic [APB_ADDR_W-1:0] addr,
                                           input logic [APB_ADDR_W-1:0] base,
                                           input logic [APB_ADDR_W-1:0] depth_words);
        logic [APB_ADDR_W+1:0] off;
        logic [APB_ADDR_W+1:0] span;
        off  = {2'b00, addr - base};
        span = {2'b00, depth_words} << 2;
        return (addr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/apb_slave_mem_array.sv
// DEPTH_WORDS x 32 storage: synchronous write, registered read with enable, cleared on reset.
// Read port holds its last loaded word until the next read enable.
module apb_slave_mem_array
    import apb_slave_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic                  re,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[widx] <= wdata;
            end
            if (re) begin
                rdata <= mem[ridx];
            end
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave memory with WAIT_STATES stretched access phases; transfer = 2+WAIT_STATES cycles, pready registered.
// APB_SLV_ERR_CHECK_EN: out-of-range accesses get pslverr, writes dropped, reads return 0; otherwise addresses alias.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int                    DEPTH_WORDS = 256,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [APB_ADDR_W-1:0] lat_addr;
    logic [APB_DATA_W-1:0] lat_wdata;
    logic                  lat_write;
    logic                  rd_err;
    logic [APB_DATA_W-1:0] arr_rdata;

    logic                  setup;
    logic                  load_rdy;
    logic                  complete;
    logic [APB_ADDR_W-1:0] cur_addr;
    logic                  cur_write;
    logic [APB_ADDR_W-1:0] cur_off;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_err;
    logic                  mem_we;
    logic                  mem_re;

    // In IDLE the decode looks at the live bus so a zero-wait read can load prdata on the setup edge.
    always_comb begin
        setup     = (state == IDLE) && pselx && !penable;
        complete  = (state == ACCESS) && pready && pselx && penable;
        cur_addr  = setup ? paddr : lat_addr;
        cur_write = setup ? pwrite : lat_write;
        cur_off   = cur_addr - ADDR_BASE;
        cur_idx   = IDX_W'(cur_off >> 2);
`ifdef APB_SLV_ERR_CHECK_EN
        cur_err   = !addr_in_range(cur_addr, ADDR_BASE, 32'(DEPTH_WORDS));
`else
        cur_err   = 1'b0;
`endif
        load_rdy  = setup ? (WAIT_STATES == 0)
                          : ((state == ACCESS) && pselx && penable && (wait_cnt == 4'd1));
        mem_re    = load_rdy && !cur_write;
        mem_we    = complete && lat_write && !cur_err;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= IDLE;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        state     <= ACCESS;
                        lat_addr  <= paddr;
                        lat_wdata <= pwdata;
                        lat_write <= pwrite;
                        wait_cnt  <= WAIT_INIT;
                        pready    <= (WAIT_STATES == 0);
                        pslverr   <= (WAIT_STATES == 0) && cur_err;
                    end
                end
                ACCESS: begin
                    if (!pselx || complete) begin
                        state    <= IDLE;
                        pready   <= 1'b0;
                        pslverr  <= 1'b0;
                        wait_cnt <= '0;
                    end else if (penable && (wait_cnt != 4'd0)) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            pready  <= 1'b1;
                            pslverr <= cur_err;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (mem_re) begin
                rd_err <= cur_err;
            end
        end
    end

    apb_slave_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .hclk  (hclk),
        .hreset(hreset),
        .we    (mem_we),
        .widx  (cur_idx),
        .wdata (lat_wdata),
        .re    (mem_re),
        .ridx  (cur_idx),
        .rdata (arr_rdata)
    );

    assign prdata = rd_err ? '0 : arr_rdata;

endmodule
